// File: rtl/arb_rr_2x1_if.sv
// Request/grant bundle between two requesters and the round-robin arbiter.
// The master modport is the requester side and the slave modport is the arbiter side.
interface arb_rr_2x1_if;
    logic [1:0] req;
    logic       done;
    logic [1:0] gnt;
    logic       gnt_vld;
    logic       idx;
    logic       tmo;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_vld,
        input  idx,
        input  tmo
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_vld,
        output idx,
        output tmo
    );
endinterface

// File: rtl/arb_rr_2x1.sv
// Two-requester round-robin arbiter with registered one-hot grant and a mandatory idle gap.
// Optional macro ARB_TIMEOUT_EN adds a hold counter that forces a release after TMO_CYCLES.
module arb_rr_2x1 #(
    parameter int unsigned TMO_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    arb_rr_2x1_if.slave      bus
);

    if (TMO_CYCLES < 2 || TMO_CYCLES > 255) begin : g_tmo_range
        $error("arb_rr_2x1: TMO_CYCLES must lie in 2..255");
    end

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e     state_q;
    logic [1:0] gnt_q;
    logic       gnt_vld_q;
    logic       idx_q;
    logic       last_q;
    logic       pick;
    logic       release_req;

    // On a tie the requester that did not own the grant most recently wins.
    always_comb begin
        pick        = (bus.req == 2'b11) ? ~last_q : bus.req[1];
        release_req = bus.done | ~bus.req[idx_q];
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q;
    logic       tmo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            gnt_q      <= 2'b00;
            gnt_vld_q  <= 1'b0;
            idx_q      <= 1'b0;
            last_q     <= 1'b1;
            hold_cnt_q <= 8'd0;
            tmo_q      <= 1'b0;
        end else begin
            tmo_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req != 2'b00) begin
                        state_q    <= StGrant;
                        gnt_q      <= pick ? 2'b10 : 2'b01;
                        gnt_vld_q  <= 1'b1;
                        idx_q      <= pick;
                        hold_cnt_q <= 8'd0;
                    end
                end
                StGrant: begin
                    // A voluntary release wins over the timeout, so TMO stays low then.
                    if (release_req) begin
                        state_q   <= StIdle;
                        gnt_q     <= 2'b00;
                        gnt_vld_q <= 1'b0;
                        last_q    <= idx_q;
                    end else if (hold_cnt_q == 8'(TMO_CYCLES - 1)) begin
                        state_q   <= StIdle;
                        gnt_q     <= 2'b00;
                        gnt_vld_q <= 1'b0;
                        last_q    <= idx_q;
                        tmo_q     <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.tmo = tmo_q;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= 2'b00;
            gnt_vld_q <= 1'b0;
            idx_q     <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req != 2'b00) begin
                        state_q   <= StGrant;
                        gnt_q     <= pick ? 2'b10 : 2'b01;
                        gnt_vld_q <= 1'b1;
                        idx_q     <= pick;
                    end
                end
                StGrant: begin
                    if (release_req) begin
                        state_q   <= StIdle;
                        gnt_q     <= 2'b00;
                        gnt_vld_q <= 1'b0;
                        last_q    <= idx_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.tmo = 1'b0;
`endif

    assign bus.gnt     = gnt_q;
    assign bus.gnt_vld = gnt_vld_q;
    assign bus.idx     = idx_q;

endmodule

// File: tb/tb_arb_rr_2x1.sv
// Bench for arb_rr_2x1: directed scenarios plus random traffic against a behavioural model.
module tb_arb_rr_2x1;

    localparam int unsigned TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    arb_rr_2x1_if bus ();

    arb_rr_2x1 #(.TMO_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: who owns the grant (-1 for nobody), who owned it last, and what IDX shows.
    int   m_owner = -1;
    int   m_last  = 1;
    int   m_idx   = 0;
    int   m_tmo   = 0;
`ifdef ARB_TIMEOUT_EN
    int   m_held  = 0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic [1:0] rq, input logic dn);
        m_tmo = 0;
        if (r) begin
            m_owner = -1;
            m_last  = 1;
            m_idx   = 0;
`ifdef ARB_TIMEOUT_EN
            m_held  = 0;
`endif
        end else if (m_owner < 0) begin
            if (rq == 2'b11)      m_owner = 1 - m_last;
            else if (rq == 2'b01) m_owner = 0;
            else if (rq == 2'b10) m_owner = 1;
            if (m_owner >= 0) begin
                m_idx = m_owner;
`ifdef ARB_TIMEOUT_EN
                m_held = 1;
`endif
            end
        end else if (dn || !rq[m_owner]) begin
            m_last  = m_owner;
            m_owner = -1;
`ifdef ARB_TIMEOUT_EN
        end else if (m_held == int'(TMO)) begin
            m_last  = m_owner;
            m_owner = -1;
            m_tmo   = 1;
        end else begin
            m_held++;
`endif
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare outputs.
    task automatic step();
        logic [1:0] eg;
        @(posedge clk);
        model_edge(rst, bus.req, bus.done);
        #1;
        eg = (m_owner < 0) ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
        check_eq("gnt", 32'(bus.gnt), 32'(eg));
        check_eq("gnt_vld", 32'(bus.gnt_vld), 32'(m_owner >= 0));
        check_eq("idx", 32'(bus.idx), 32'(m_idx));
        check_eq("tmo", 32'(bus.tmo), 32'(m_tmo));
        check_eq("gnt_not_11", 32'(bus.gnt == 2'b11), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req  = 2'b00;
        bus.done = 1'b0;
        rst      = 1'b1;
        step();
        step();
        check_eq("reset_gnt", 32'(bus.gnt), 32'd0);
        check_eq("reset_idx", 32'(bus.idx), 32'd0);
        rst = 1'b0;

        // Round-robin sequence with DONE pulsed after each grant.
        bus.req = 2'b11;
        step(); check_eq("rr0_gnt", 32'(bus.gnt), 32'd1); check_eq("rr0_idx", 32'(bus.idx), 32'd0);
        bus.done = 1'b1;
        step(); check_eq("rr1_gnt", 32'(bus.gnt), 32'd0);
        bus.done = 1'b0;
        step(); check_eq("rr2_gnt", 32'(bus.gnt), 32'd2); check_eq("rr2_idx", 32'(bus.idx), 32'd1);
        bus.done = 1'b1;
        step(); check_eq("rr3_gnt", 32'(bus.gnt), 32'd0); check_eq("rr3_idx", 32'(bus.idx), 32'd1);
        bus.done = 1'b0;
        step(); check_eq("rr4_gnt", 32'(bus.gnt), 32'd1); check_eq("rr4_idx", 32'(bus.idx), 32'd0);
        bus.req = 2'b00;
        step(); check_eq("rr_rel_gnt", 32'(bus.gnt), 32'd0);

        // Requester 0 alone for five grant cycles, then drops its request.
        bus.req = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step(); check_eq("hold0_gnt", 32'(bus.gnt), 32'd1);
        end
        bus.req = 2'b00;
        step(); check_eq("drop0_gnt", 32'(bus.gnt), 32'd0);
        bus.req = 2'b11;
        step(); check_eq("after_last0_gnt", 32'(bus.gnt), 32'd2);
        bus.req = 2'b00;
        step();

        // DONE while idle does nothing.
        bus.done = 1'b1;
        step(); check_eq("done_idle_gnt", 32'(bus.gnt), 32'd0);
        bus.done = 1'b0;

        // Owner 1 keeps the grant while requester 0 toggles.
        bus.req = 2'b10;
        step(); check_eq("own1_gnt", 32'(bus.gnt), 32'd2);
        for (int i = 0; i < 8; i++) begin
            bus.req = {1'b1, i[0]};
            step();
            check_eq("toggle_gnt", 32'(bus.gnt), 32'd2);
            check_eq("toggle_idx", 32'(bus.idx), 32'd1);
        end

        // Reset during grant to requester 1 aborts it; requester 0 wins afterwards.
        bus.req = 2'b11;
        step(); check_eq("pre_rst_gnt", 32'(bus.gnt), 32'd2);
        rst = 1'b1;
        step(); check_eq("mid_rst_gnt", 32'(bus.gnt), 32'd0); check_eq("mid_rst_idx", 32'(bus.idx), 32'd0);
        rst = 1'b0;
        step(); check_eq("post_rst_gnt", 32'(bus.gnt), 32'd1);
        bus.req = 2'b00;
        step();

`ifdef ARB_TIMEOUT_EN
        // Held request without DONE is cut off by the timeout and re-granted after one idle.
        bus.req = 2'b10;
        for (int i = 0; i < int'(TMO); i++) begin
            step(); check_eq("tmo_hold_gnt", 32'(bus.gnt), 32'd2);
        end
        step(); check_eq("tmo_rel_gnt", 32'(bus.gnt), 32'd0); check_eq("tmo_pulse", 32'(bus.tmo), 32'd1);
        step(); check_eq("tmo_regrant", 32'(bus.gnt), 32'd2); check_eq("tmo_low", 32'(bus.tmo), 32'd0);
        bus.req = 2'b00;
        step();
`endif

        // Random traffic, requests biased high so grants persist, occasional resets.
        for (int i = 0; i < 600; i++) begin
            bus.req  = 2'($urandom_range(0, 3) | (($urandom_range(0, 3) == 0) ? 0 : 1));
            if ($urandom_range(0, 2) == 0) bus.req = 2'($urandom_range(0, 3));
            bus.done = ($urandom_range(0, 5) == 0);
            rst      = ($urandom_range(0, 60) == 0);
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
